// File: rtl/dma_cmd_executor_if.sv
// dma_cmd_executor_if
//   Bundles the dispatcher command link, the read-burst request port and the
//   write-completion/status signals of the DMA command executor.
//   Modports:
//     master - dispatcher / datapath side: drives commands, clears, request
//              ready and line-write completions; observes status.
//     slave  - executor side: consumes commands, issues read bursts,
//              reports queue/FSM status and the completion interrupt.
interface dma_cmd_executor_if #(
    parameter int SRC_ADDR_WIDTH    = 48,
    parameter int DST_ADDR_WIDTH    = 48,
    parameter int XFER_LENGTH_WIDTH = 40,
    parameter int CMDQ_DEPTH_LOG2   = 4,
    parameter int BURST_CNT_WIDTH   = 5
) ();
    logic                         sclr;
    logic                         new_cmd;
    logic [SRC_ADDR_WIDTH-1:0]    cmd_src_addr;
    logic [DST_ADDR_WIDTH-1:0]    cmd_dst_addr;
    logic [XFER_LENGTH_WIDTH-1:0] cmd_xfer_length;
    logic                         clear_irq;

    logic                         rd_req_valid;
    logic                         rd_req_ready;
    logic [SRC_ADDR_WIDTH-1:0]    rd_req_addr;
    logic [BURST_CNT_WIDTH-1:0]   rd_req_burstcnt;
    logic [DST_ADDR_WIDTH-1:0]    cur_dst_addr;
    logic                         wr_line_done;

    logic                         controller_busy_rd;
    logic                         controller_busy_wr;
    logic                         cmdq_empty;
    logic                         cmdq_full;
    logic                         cmdq_underflow;
    logic                         cmdq_overflow;
    logic [CMDQ_DEPTH_LOG2:0]     cmdq_usedw;
    logic                         irq;
    logic                         irq_pulse;
    logic [3:0]                   rd_ctrl_fsm_cs;
    logic [15:0]                  rd_xfer_remaining;
    logic [3:0]                   wr_ctrl_fsm_cs;
    logic [15:0]                  wr_xfer_remaining;

    modport master (
        output sclr, new_cmd, cmd_src_addr, cmd_dst_addr, cmd_xfer_length,
               clear_irq, rd_req_ready, wr_line_done,
        input  rd_req_valid, rd_req_addr, rd_req_burstcnt, cur_dst_addr,
               controller_busy_rd, controller_busy_wr, cmdq_empty, cmdq_full,
               cmdq_underflow, cmdq_overflow, cmdq_usedw, irq, irq_pulse,
               rd_ctrl_fsm_cs, rd_xfer_remaining, wr_ctrl_fsm_cs,
               wr_xfer_remaining
    );

    modport slave (
        input  sclr, new_cmd, cmd_src_addr, cmd_dst_addr, cmd_xfer_length,
               clear_irq, rd_req_ready, wr_line_done,
        output rd_req_valid, rd_req_addr, rd_req_burstcnt, cur_dst_addr,
               controller_busy_rd, controller_busy_wr, cmdq_empty, cmdq_full,
               cmdq_underflow, cmdq_overflow, cmdq_usedw, irq, irq_pulse,
               rd_ctrl_fsm_cs, rd_xfer_remaining, wr_ctrl_fsm_cs,
               wr_xfer_remaining
    );
endinterface

// File: rtl/dma_cmd_executor.sv
// dma_cmd_executor
//   Controller-side endpoint of the DMA command link. Commands are queued in
//   a small FIFO and executed one at a time: the read FSM splits each command
//   into 64-byte-line read bursts of at most MAX_BURST lines, the write FSM
//   counts completed line writes and raises a sticky irq plus a one-cycle
//   irq_pulse when the whole transfer has landed.
//   Ports:
//     clk      - clock
//     reset_n  - asynchronous active-low reset
//     bus      - dma_cmd_executor_if.slave: command inputs, read request
//                port, write completion input, status and interrupt outputs
module dma_cmd_executor #(
    parameter int SRC_ADDR_WIDTH    = 48,
    parameter int DST_ADDR_WIDTH    = 48,
    parameter int XFER_LENGTH_WIDTH = 40,
    parameter int CMDQ_DEPTH_LOG2   = 4,
    parameter int MAX_BURST         = 16,
    parameter int BURST_CNT_WIDTH   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    dma_cmd_executor_if.slave   bus
);
    localparam int DEPTH   = 1 << CMDQ_DEPTH_LOG2;
    // ceil(len/64) needs one bit more than len[XFER_LENGTH_WIDTH-1:6]
    localparam int LINES_W = XFER_LENGTH_WIDTH - 5;
    localparam int ENTRY_W = SRC_ADDR_WIDTH + DST_ADDR_WIDTH + XFER_LENGTH_WIDTH;

    localparam logic [3:0] RD_IDLE   = 4'd0;
    localparam logic [3:0] RD_LOAD   = 4'd1;
    localparam logic [3:0] RD_ISSUE  = 4'd2;
    localparam logic [3:0] RD_DRAIN  = 4'd3;
    localparam logic [3:0] WR_IDLE   = 4'd0;
    localparam logic [3:0] WR_ACTIVE = 4'd1;
    localparam logic [3:0] WR_DONE   = 4'd2;

    localparam logic [CMDQ_DEPTH_LOG2-1:0] PTR_ONE   = {{(CMDQ_DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [CMDQ_DEPTH_LOG2:0]   USEDW_ONE = {{CMDQ_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [LINES_W-1:0]         LINES_ONE = {{(LINES_W-1){1'b0}}, 1'b1};

    logic [3:0]                   rd_state_q, rd_state_d;
    logic [3:0]                   wr_state_q, wr_state_d;
    logic [SRC_ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic [LINES_W-1:0]           rd_rem_q, rd_rem_d;
    logic [LINES_W-1:0]           wr_rem_q, wr_rem_d;
    logic [DST_ADDR_WIDTH-1:0]    dst_q, dst_d;
    logic [CMDQ_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CMDQ_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CMDQ_DEPTH_LOG2:0]     usedw_q, usedw_d;
    logic                         ovf_q, ovf_d;
    logic                         unf_q, unf_d;
    logic                         irq_q, irq_d;
    logic                         irq_pulse_q, irq_pulse_d;

    logic [ENTRY_W-1:0]           mem_q [DEPTH];
    logic [ENTRY_W-1:0]           head;
    logic [SRC_ADDR_WIDTH-1:0]    head_src;
    logic [DST_ADDR_WIDTH-1:0]    head_dst;
    logic [XFER_LENGTH_WIDTH-1:0] head_len;
    logic [LINES_W-1:0]           head_lines;

    logic                         cmdq_empty;
    logic                         cmdq_full;
    logic                         push;
    logic                         pop;
    logic                         rd_handshake;
    logic [BURST_CNT_WIDTH-1:0]   burstcnt;

    assign head     = mem_q[rd_ptr_q];
    assign head_len = head[XFER_LENGTH_WIDTH-1:0];
    assign head_dst = head[XFER_LENGTH_WIDTH +: DST_ADDR_WIDTH];
    assign head_src = head[XFER_LENGTH_WIDTH+DST_ADDR_WIDTH +: SRC_ADDR_WIDTH];
    // Round up to whole 64-byte lines
    assign head_lines = {1'b0, head_len[XFER_LENGTH_WIDTH-1:6]}
                      + {{(LINES_W-1){1'b0}}, |head_len[5:0]};

    assign cmdq_empty = (usedw_q == '0);
    // usedw never exceeds DEPTH, so its top bit alone marks a full queue
    assign cmdq_full  = usedw_q[CMDQ_DEPTH_LOG2];

    assign push = bus.new_cmd && !cmdq_full && !bus.sclr;
    // A new command waits until both FSMs are idle and the previous irq was acknowledged
    assign pop  = (rd_state_q == RD_IDLE) && (wr_state_q == WR_IDLE)
               && !cmdq_empty && !irq_q && !bus.sclr;

    assign burstcnt = (rd_rem_q >= LINES_W'(MAX_BURST)) ? BURST_CNT_WIDTH'(MAX_BURST)
                                                         : rd_rem_q[BURST_CNT_WIDTH-1:0];
    assign rd_handshake = (rd_state_q == RD_ISSUE) && bus.rd_req_ready;

    // Command queue bookkeeping: pointers, occupancy and sticky overflow/underflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      usedw_d = usedw_q + USEDW_ONE;
        else if (pop && !push) usedw_d = usedw_q - USEDW_ONE;
        if (bus.new_cmd && cmdq_full) ovf_d = 1'b1;
        // A line completion is only legal while lines are still outstanding
        if (bus.wr_line_done && !((wr_state_q == WR_ACTIVE) && (wr_rem_q != '0)))
            unf_d = 1'b1;
        if (bus.sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
    end

    // Read FSM: latch the popped command and issue line bursts until none remain
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        dst_d      = dst_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (pop) begin
                    rd_state_d = RD_LOAD;
                    rd_addr_d  = head_src;
                    rd_rem_d   = head_lines;
                    dst_d      = head_dst;
                end
            end
            RD_LOAD: rd_state_d = (rd_rem_q != '0) ? RD_ISSUE : RD_DRAIN;
            RD_ISSUE: begin
                if (rd_handshake) begin
                    rd_addr_d = rd_addr_q + (SRC_ADDR_WIDTH'(burstcnt) << 6);
                    rd_rem_d  = rd_rem_q - LINES_W'(burstcnt);
                    if (rd_rem_q == LINES_W'(burstcnt)) rd_state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: if (wr_state_q == WR_IDLE) rd_state_d = RD_IDLE;
            default:  rd_state_d = RD_IDLE;
        endcase
        if (bus.sclr) begin
            rd_state_d = RD_IDLE;
            rd_addr_d  = '0;
            rd_rem_d   = '0;
            dst_d      = '0;
        end
    end

    // Write FSM: count line completions, then signal the end of transfer
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_rem_d    = wr_rem_q;
        irq_d       = irq_q;
        irq_pulse_d = 1'b0;
        if (bus.clear_irq) irq_d = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (pop) begin
                    wr_state_d = WR_ACTIVE;
                    wr_rem_d   = head_lines;
                end
            end
            WR_ACTIVE: begin
                if (wr_rem_q == '0)         wr_state_d = WR_DONE;
                else if (bus.wr_line_done)  wr_rem_d   = wr_rem_q - LINES_ONE;
            end
            WR_DONE: begin
                // Completion overrides a coincident clear_irq
                wr_state_d  = WR_IDLE;
                irq_d       = 1'b1;
                irq_pulse_d = 1'b1;
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (bus.sclr) begin
            wr_state_d  = WR_IDLE;
            wr_rem_d    = '0;
            irq_d       = 1'b0;
            irq_pulse_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q  <= RD_IDLE;
            wr_state_q  <= WR_IDLE;
            rd_addr_q   <= '0;
            rd_rem_q    <= '0;
            wr_rem_q    <= '0;
            dst_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            irq_q       <= 1'b0;
            irq_pulse_q <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rd_addr_q   <= rd_addr_d;
            rd_rem_q    <= rd_rem_d;
            wr_rem_q    <= wr_rem_d;
            dst_q       <= dst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usedw_q     <= usedw_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            irq_q       <= irq_d;
            irq_pulse_q <= irq_pulse_d;
        end
    end

    // Queue storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_xfer_length};
    end

    assign bus.rd_req_valid       = (rd_state_q == RD_ISSUE);
    assign bus.rd_req_addr        = rd_addr_q & ~SRC_ADDR_WIDTH'(63);
    assign bus.rd_req_burstcnt    = burstcnt;
    assign bus.cur_dst_addr       = dst_q;
    assign bus.controller_busy_rd = (rd_state_q != RD_IDLE);
    assign bus.controller_busy_wr = (wr_state_q != WR_IDLE);
    assign bus.cmdq_empty         = cmdq_empty;
    assign bus.cmdq_full          = cmdq_full;
    assign bus.cmdq_underflow     = unf_q;
    assign bus.cmdq_overflow      = ovf_q;
    assign bus.cmdq_usedw         = usedw_q;
    assign bus.irq                = irq_q;
    assign bus.irq_pulse          = irq_pulse_q;
    assign bus.rd_ctrl_fsm_cs     = rd_state_q;
    assign bus.wr_ctrl_fsm_cs     = wr_state_q;
    // Line counts of 65536 or more read as all ones
    assign bus.rd_xfer_remaining  = (|rd_rem_q[LINES_W-1:16]) ? 16'hFFFF : rd_rem_q[15:0];
    assign bus.wr_xfer_remaining  = (|wr_rem_q[LINES_W-1:16]) ? 16'hFFFF : wr_rem_q[15:0];
endmodule

// File: doc/dma_cmd_executor.md
Name: dma_cmd_executor

Overview:
- Controller-side endpoint of the DMA dispatcher/controller command link: consumes the dispatcher's command fields plus `new_cmd` pulse and returns busy, command-queue status, controller status and interrupt.
- Queues commands and executes them one at a time.
- Read side splits each command into line-granular read bursts on a valid/ready request port.
- Write side counts completed line writes to detect end of transfer and raise `irq`.

Parameters:
SRC_ADDR_WIDTH, 48, source byte-address width
DST_ADDR_WIDTH, 48, destination byte-address width
XFER_LENGTH_WIDTH, 40, transfer length width (bytes)
CMDQ_DEPTH_LOG2, 4, log2 command-queue depth (16 entries)
MAX_BURST, 16, max lines per read burst (power of 2, ≥1)
BURST_CNT_WIDTH, 5, width of burst count = clog2(MAX_BURST)+1

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sclr  in  1  synchronous clear from dispatcher
new_cmd  in  1  one-cycle command strobe
cmd_src_addr  in  SRC_ADDR_WIDTH  source start byte address
cmd_dst_addr  in  DST_ADDR_WIDTH  destination start byte address
cmd_xfer_length  in  XFER_LENGTH_WIDTH  length in bytes
clear_irq  in  1  clears irq
rd_req_valid  out  1  read burst request valid
rd_req_ready  in  1  read burst request accepted
rd_req_addr  out  SRC_ADDR_WIDTH  burst start byte address (64B aligned)
rd_req_burstcnt  out  BURST_CNT_WIDTH  lines in burst
cur_dst_addr  out  DST_ADDR_WIDTH  destination start of active command
wr_line_done  in  1  one line written to destination
controller_busy_rd  out  1  read FSM not idle
controller_busy_wr  out  1  write FSM not idle
cmdq_empty, cmdq_full, cmdq_underflow, cmdq_overflow  out  1 each  queue status
cmdq_usedw  out  CMDQ_DEPTH_LOG2+1  queue occupancy
irq  out  1  sticky completion interrupt
irq_pulse  out  1  one-cycle completion pulse
rd_ctrl_fsm_cs  out  4  read FSM state
rd_xfer_remaining  out  16  lines left to request, saturated
wr_ctrl_fsm_cs  out  4  write FSM state
wr_xfer_remaining  out  16  lines left to complete, saturated

Behaviour:
- Reset (`reset_n` low, async): all outputs 0, queue empty, both FSMs IDLE. Exception: `cmdq_empty` = 1.
- `sclr` (synchronous, highest priority): same state as reset. Flushes the queue, abandons the active command, drops `rd_req_valid` immediately, clears `irq` and the sticky flags. `new_cmd` coincident with `sclr` is discarded.
- Line = 64B. `lines = ceil(len/64)`. Address bits [5:0] are forced to 0 on `rd_req_addr`.
- Queue:
  - `new_cmd` while not full → push; `usedw` updates the next cycle.
  - `new_cmd` while full → command dropped, `cmdq_overflow` set sticky.
  - Push and pop in the same cycle → `usedw` unchanged.
  - `cmdq_full` is set when `usedw` == 2^CMDQ_DEPTH_LOG2.
- Pop occurs only when both FSMs are IDLE, the queue is non-empty, and `irq` is 0.
  - A new command does not start until the dispatcher clears `irq`.
  - `clear_irq` and pop may coincide: pop occurs the cycle after `irq` falls.
- Read FSM encoding: IDLE=0, LOAD=1, ISSUE=2, DRAIN=3.
  - IDLE → LOAD on pop (latch addresses, compute lines).
  - LOAD → ISSUE if lines > 0, else → DRAIN.
  - In ISSUE, `rd_req_valid` = 1 with `burstcnt = min(MAX_BURST, rd_remaining)`. Address, burstcnt and valid are held stable until `rd_req_ready`.
  - On handshake: `addr += 64*burstcnt`, `rd_remaining -= burstcnt`. When `rd_remaining` reaches 0 → DRAIN.
  - DRAIN → IDLE when the write FSM returns to IDLE.
- Write FSM encoding: IDLE=0, ACTIVE=1, DONE=2.
  - IDLE → ACTIVE on pop, with `wr_remaining = lines`.
  - Each `wr_line_done` decrements `wr_remaining`.
  - At 0 (or lines == 0) → DONE.
  - DONE → IDLE the next cycle, setting `irq` = 1 and `irq_pulse` = 1 for exactly that cycle.
- `wr_line_done` with `wr_remaining` == 0 or FSM not ACTIVE → ignored, `cmdq_underflow` set sticky.
- `wr_line_done` may arrive before the read burst completes; no ordering is enforced.
- `irq` stays high until `clear_irq`. `clear_irq` in the same cycle as completion → `irq` ends at 1 (set wins).
- `busy_rd` = read FSM ≠ IDLE; `busy_wr` = write FSM ≠ IDLE.
- `*_remaining` outputs saturate to 16'hFFFF when the true value is ≥ 65536.
- Address increments wrap modulo 2^SRC_ADDR_WIDTH with no error.

Test Plan:
1. Single command src=0x1000, len=256: 4 lines; one burst addr=0x1000, burstcnt=4; 4 `wr_line_done` → `irq_pulse` one cycle, `irq` held until `clear_irq`.
2. len=2048 (32 lines), `rd_req_ready` toggling every other cycle: bursts at 0x0 and 0x400 with burstcnt=16 each; addr/cnt stable while stalled; `rd_xfer_remaining` 32→16→0.
3. len=100: 2 lines requested. len=0: no `rd_req_valid`, `irq` within 4 cycles of pop.
4. 17 back-to-back `new_cmd` while blocked on `irq`=1: `usedw`=16, `full`=1, `overflow`=1 sticky; the next command pops only after `clear_irq`.
5. Spurious `wr_line_done` in IDLE → `underflow`=1, counters unchanged. Then `sclr` mid-ISSUE → `rd_req_valid`=0 next cycle, queue empty, flags cleared.
6. `reset_n` asserted mid-transfer, with no clock edge → all outputs at reset values immediately. Length ≥ 4MiB → `rd_xfer_remaining` reads 16'hFFFF.
